// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Optional parity support is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 5208;
    localparam int UART_DATA_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef UART_RX_PARITY_EN
        , ST_PARITY
`endif
    } uart_state_t;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: rx synchronizer, frame FSM, bit and index counters.
// 8N1 by default; UART_RX_PARITY_EN selects 8E1 with a parity check.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx,
    output logic [UART_DATA_W-1:0] o_byte,
    output logic                   o_byte_valid,
    output logic                   o_byte_err
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic                   r_rx_meta;
    logic                   r_rxs;
    logic                   r_rxs_d;
    uart_state_t            r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_idx;
    logic [UART_DATA_W-1:0] r_shift;

    uart_state_t            w_state_next;
    logic [CW-1:0]          w_cnt_next;
    logic [2:0]             w_idx_next;
    logic [UART_DATA_W-1:0] w_shift_next;
    logic                   w_byte_valid;
    logic                   w_byte_err;
    logic                   w_stop_ok;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bad;
    logic                   w_par_bad_next;
    assign w_stop_ok = r_rxs && !r_par_bad;
`else
    assign w_stop_ok = r_rxs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_rx_meta <= i_rx;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_shift   <= w_shift_next;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CW'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_byte_valid = 1'b0;
        w_byte_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (r_rxs_d && !r_rxs) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (r_cnt == CNT_HALF) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = r_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_rxs, r_shift[UART_DATA_W-1:1]};
                    w_idx_next   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next     = '0;
                    w_par_bad_next = (r_rxs != even_parity(r_shift));
                    w_state_next   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                    w_byte_valid = w_stop_ok;
                    w_byte_err   = !w_stop_ok;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = w_byte_valid;
    assign o_byte_err   = w_byte_err;

endmodule

// File: rtl/uart_operand_rx.sv
// Pairs received bytes into adder operands A and B with a one-cycle strobe.
// Frame format (8N1, or 8E1 with UART_RX_PARITY_EN) is set in uart_byte_rx.
module uart_operand_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] op_a,
    output logic [UART_DATA_W-1:0] op_b,
    output logic                   op_valid,
    output logic                   frame_err
);

    logic [UART_DATA_W-1:0] w_byte;
    logic                   w_byte_valid;
    logic                   w_byte_err;

    logic                   r_byte_sel;
    logic [UART_DATA_W-1:0] r_hold_a;
    logic [UART_DATA_W-1:0] r_op_a;
    logic [UART_DATA_W-1:0] r_op_b;
    logic                   r_op_valid;
    logic                   r_frame_err;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_byte_err   (w_byte_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_sel  <= 1'b0;
            r_hold_a    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_op_valid  <= 1'b0;
            r_frame_err <= w_byte_err;
            // A bad frame drops any pending A so the next good byte is A again.
            if (w_byte_err) begin
                r_byte_sel <= 1'b0;
            end else if (w_byte_valid) begin
                if (!r_byte_sel) begin
                    r_hold_a   <= w_byte;
                    r_byte_sel <= 1'b1;
                end else begin
                    r_op_a     <= r_hold_a;
                    r_op_b     <= w_byte;
                    r_op_valid <= 1'b1;
                    r_byte_sel <= 1'b0;
                end
            end
        end
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign op_valid  = r_op_valid;
    assign frame_err = r_frame_err;

endmodule

// File: doc/uart_operand_rx.md
# uart_operand_rx

Serial receive front end that feeds the 8-bit adder with its two operands. It deserializes UART frames from the far FPGA and pairs consecutive bytes into operand A (first byte) and operand B (second byte). Each completed pair is presented with a one-cycle valid strobe. It sits directly upstream of the adder; the adder's result is consumed by the transmit path.

## Interface
- CLKS_PER_BIT, default 5208: clock cycles per bit (50 MHz / 9600 baud). Must be ≥ 4.
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- op_a  out  8  operand A; holds its value until the next pair completes.
- op_b  out  8  operand B; holds its value until the next pair completes.
- op_valid  out  1  one-cycle pulse when op_a and op_b update together.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

Clock and reset are fixed: one clock, `clk`; reset `rst` is synchronous and active-high.

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1. All later logic uses the synchronized bit rxs.
- Bit counter counts 0..CLKS_PER_BIT-1. Bit index counts 0..7.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: a 1→0 transition on rxs moves to START and clears the counter.
- START: at count CLKS_PER_BIT/2-1 (mid start bit), re-check rxs.
  - rxs=1: treat as a glitch; return to IDLE with no error.
  - rxs=0: clear the counter and move to DATA.
- DATA: sample rxs each time the counter reaches CLKS_PER_BIT-1 (mid-bit). Bits are shifted in LSB first. After bit 7, go to PARITY or STOP.
- STOP: take the mid-bit sample.
  - rxs=1: byte accepted.
  - rxs=0: frame_err pulses and the byte is dropped.
  - Either way, return to IDLE immediately. The second half of the stop bit is not waited for, so back-to-back frames are received.
- Pair collector uses flag byte_sel (reset 0).
  - Accepted byte with byte_sel=0: store it in a hidden A register; set byte_sel=1.
  - Accepted byte with byte_sel=1: op_a←hidden A, op_b←byte, op_valid=1 for one cycle; clear byte_sel.
- On any frame_err: clear byte_sel and discard any pending first byte. Resynchronization always restarts at operand A.
- op_a and op_b change only on a completed pair.
- Reset values: op_a=0x00, op_b=0x00, op_valid=0, frame_err=0, state=IDLE, byte_sel=0, counters=0.
- rst asserted mid-frame abandons the frame and the pending pair. No strobe is generated.

## Timing
- Input latency: 2 clocks of synchronizer delay.
- Stop sample falls 9.5 bit-times after the start edge as seen on rxs (10.5 with parity).
- op_valid and frame_err assert on the cycle after the stop (or parity) sample. Each lasts exactly one cycle.
- op_valid and frame_err are never asserted on the same cycle.
- Minimum gap between two op_valid pulses: 2 frames (20 bit-times for 8N1).

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: frames are 8E1. PARITY state samples an even-parity bit at mid-bit.
  - Mismatch: frame_err pulses after the stop sample, the byte is dropped, and the pair resets.
  - The stop bit is still checked.
- Undefined: frames are 8N1. The PARITY state and its logic do not exist.

## Structure
- Shared package `uart_pkg`: FSM state enum, default CLKS_PER_BIT constant, and data width constant (8). The transmit side uses the same package.
- Sub-module `uart_byte_rx` contains the synchronizer, FSM, and counters. It outputs byte[7:0], byte_valid, and byte_err.
- Top `uart_operand_rx` contains only the pair collector and output registers.

## Test plan
- Reset with rx=1 held for 100 cycles → op_a=0x00, op_b=0x00, op_valid=0, frame_err=0 throughout.
- CLKS_PER_BIT=16; send 0x35 then 0x5A back to back (8N1) → one op_valid pulse with op_a=0x35, op_b=0x5A. No strobe after the first byte alone.
- rx low for 4 clocks then high → no byte accepted, no frame_err, state returns to IDLE.
- Send 0x11 with stop bit=0, then 0x22 and 0x33 → one frame_err pulse, then op_valid with op_a=0x22, op_b=0x33.
- Send 0x44, assert rst for 1 cycle during data bit 3 of the second byte, then send 0x66 and 0x77 → outputs return to 0, then op_valid with op_a=0x66, op_b=0x77.
- With `UART_RX_PARITY_EN` defined: send 0x07 with parity bit=0 (wrong) → frame_err. Then send 0x07 with parity=1 and 0x03 with parity=0 → op_a=0x07, op_b=0x03, op_valid.
